// File: rtl/decoder_sync.sv
// Debounced, registered KEY_W-to-2**KEY_W one-hot decoder with enable.
// A raw key code must hold steady for STABLE_CYCLES samples before it is
// committed; each commit raises a one-cycle valid strobe. In level mode opt
// holds the last committed one-hot code; in pulse mode opt is driven only
// in the commit cycle.
module decoder_sync #(
    parameter int KEY_W         = 2,
    parameter int STABLE_CYCLES = 4,
    parameter bit PULSE_MODE    = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  En,
    input  logic [KEY_W-1:0]      key,
    output logic [2**KEY_W-1:0]   opt,
    output logic                  valid,
    output logic [KEY_W-1:0]      code
);

    localparam int OUT_W = 2**KEY_W;
    localparam int CW    = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    // Decode a key code into a single set bit; never produces multi-hot.
    function automatic logic [OUT_W-1:0] onehot(input logic [KEY_W-1:0] k);
        logic [OUT_W-1:0] f;
        f    = {OUT_W{1'b0}};
        f[k] = 1'b1;
        return f;
    endfunction

    state_t            state_r, state_nxt;
    logic [KEY_W-1:0]  key_q_r;
    logic [CW-1:0]     cnt_r;
    logic [OUT_W-1:0]  opt_r, opt_nxt;
    logic              valid_r, valid_nxt;
    logic [KEY_W-1:0]  code_r, code_nxt;
    logic              committed_r, committed_nxt;
    logic              stable_s;

    // The sample matches the previous one and has done so long enough.
    assign stable_s = (key == key_q_r) && (cnt_r == CNT_MAX);

    // Sampler: tracks the previous key and counts consecutive equal samples.
    // It runs regardless of FSM state so a steady key is already qualified
    // when the decoder is enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_q_r <= {KEY_W{1'b0}};
            cnt_r   <= {CW{1'b0}};
        end else begin
            key_q_r <= key;
            if (key != key_q_r) begin
                cnt_r <= {CW{1'b0}};
            end else if (cnt_r == CNT_MAX) begin
                cnt_r <= cnt_r;
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
        end
    end

    // FSM state and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_OFF;
            opt_r       <= {OUT_W{1'b0}};
            valid_r     <= 1'b0;
            code_r      <= {KEY_W{1'b0}};
            committed_r <= 1'b0;
        end else begin
            state_r     <= state_nxt;
            opt_r       <= opt_nxt;
            valid_r     <= valid_nxt;
            code_r      <= code_nxt;
            committed_r <= committed_nxt;
        end
    end

    // Next-state and next-output logic. A commit is suppressed only when the
    // stable key equals a code already committed since the last enable, so
    // re-enabling always recommits.
    always_comb begin
        state_nxt     = state_r;
        valid_nxt     = 1'b0;
        code_nxt      = code_r;
        committed_nxt = committed_r;
        if (PULSE_MODE) begin
            opt_nxt = {OUT_W{1'b0}};
        end else begin
            opt_nxt = opt_r;
        end

        if (!En) begin
            state_nxt     = ST_OFF;
            opt_nxt       = {OUT_W{1'b0}};
            committed_nxt = 1'b0;
        end else begin
            case (state_r)
                ST_OFF: begin
                    state_nxt     = ST_SETTLE;
                    opt_nxt       = {OUT_W{1'b0}};
                    committed_nxt = 1'b0;
                end
                ST_SETTLE: begin
                    if (stable_s) begin
                        state_nxt = ST_HOLD;
                        if (!committed_r || (key_q_r != code_r)) begin
                            code_nxt      = key_q_r;
                            opt_nxt       = onehot(key_q_r);
                            valid_nxt     = 1'b1;
                            committed_nxt = 1'b1;
                        end else begin
                            valid_nxt = 1'b0;
                        end
                    end else begin
                        state_nxt = ST_SETTLE;
                    end
                end
                ST_HOLD: begin
                    if (key != code_r) begin
                        state_nxt = ST_SETTLE;
                    end else begin
                        state_nxt = ST_HOLD;
                    end
                end
                default: begin
                    state_nxt     = ST_OFF;
                    opt_nxt       = {OUT_W{1'b0}};
                    committed_nxt = 1'b0;
                end
            endcase
        end
    end

    assign opt   = opt_r;
    assign valid = valid_r;
    assign code  = code_r;

endmodule

// File: tb/tb_decoder_sync.sv
// Directed testbench for decoder_sync: level mode (STABLE_CYCLES=4),
// pulse mode, and STABLE_CYCLES=1, with hand-computed expected values.
module tb_decoder_sync;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       en0 = 1'b0, en_p = 1'b0, en_s = 1'b0;
    logic [1:0] key0 = 2'b01, key_p = 2'b11, key_s = 2'b00;
    logic [3:0] opt0, opt_p, opt_s;
    logic       valid0, valid_p, valid_s;
    logic [1:0] code0, code_p, code_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decoder_sync #(.KEY_W(2), .STABLE_CYCLES(4), .PULSE_MODE(1'b0)) dut0 (
        .clk(clk), .rst(rst), .En(en0), .key(key0),
        .opt(opt0), .valid(valid0), .code(code0));

    decoder_sync #(.KEY_W(2), .STABLE_CYCLES(4), .PULSE_MODE(1'b1)) dut_p (
        .clk(clk), .rst(rst), .En(en_p), .key(key_p),
        .opt(opt_p), .valid(valid_p), .code(code_p));

    decoder_sync #(.KEY_W(2), .STABLE_CYCLES(1), .PULSE_MODE(1'b0)) dut_s (
        .clk(clk), .rst(rst), .En(en_s), .key(key_s),
        .opt(opt_s), .valid(valid_s), .code(code_s));

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // n edges on dut0 with valid low and opt at a fixed value
    task automatic quiet0(input int n, input logic [3:0] eo, input string tag);
        for (int i = 0; i < n; i++) begin
            tick();
            check_val({tag, "_valid"}, {7'd0, valid0}, 8'd0);
            check_val({tag, "_opt"}, {4'd0, opt0}, {4'd0, eo});
        end
    endtask

    // one edge on dut0 expected to commit
    task automatic commit0(input logic [3:0] eo, input logic [1:0] ec, input string tag);
        tick();
        check_val({tag, "_valid"}, {7'd0, valid0}, 8'd1);
        check_val({tag, "_opt"}, {4'd0, opt0}, {4'd0, eo});
        check_val({tag, "_code"}, {6'd0, code0}, {6'd0, ec});
    endtask

    initial begin
        // 1: reset, then disabled with key=01 -> nothing happens
        tick(); tick();
        rst = 1'b0;
        check_val("rst_opt", {4'd0, opt0}, 8'd0);
        check_val("rst_valid", {7'd0, valid0}, 8'd0);
        check_val("rst_code", {6'd0, code0}, 8'd0);
        quiet0(10, 4'b0000, "off");

        // 2: enable and key=10 together -> commit on 5th edge
        en0 = 1'b1; key0 = 2'b10;
        quiet0(4, 4'b0000, "en_settle");
        commit0(4'b0100, 2'b10, "en_commit");
        quiet0(1, 4'b0100, "en_after");
        key0 = 2'b11;
        quiet0(4, 4'b0100, "chg_settle");
        commit0(4'b1000, 2'b11, "chg_commit");
        quiet0(1, 4'b1000, "chg_after");

        // 3: hold at 01, then glitches of 2 and 3 cycles never commit
        key0 = 2'b01;
        quiet0(4, 4'b1000, "to01_settle");
        commit0(4'b0010, 2'b01, "to01_commit");
        quiet0(1, 4'b0010, "to01_after");
        key0 = 2'b11;
        quiet0(2, 4'b0010, "glitch2");
        key0 = 2'b01;
        quiet0(8, 4'b0010, "glitch2_back");
        key0 = 2'b11;
        quiet0(3, 4'b0010, "glitch3");
        key0 = 2'b01;
        quiet0(8, 4'b0010, "glitch3_back");
        check_val("glitch_code", {6'd0, code0}, 8'd1);

        // 4: hold at 0100, disable one edge, re-enable recommits same key
        key0 = 2'b10;
        quiet0(4, 4'b0010, "to10_settle");
        commit0(4'b0100, 2'b10, "to10_commit");
        quiet0(1, 4'b0100, "to10_after");
        en0 = 1'b0;
        quiet0(1, 4'b0000, "dis");
        check_val("dis_code", {6'd0, code0}, 8'd2);
        en0 = 1'b1;
        quiet0(1, 4'b0000, "reen_settle");
        commit0(4'b0100, 2'b10, "reen_commit");
        quiet0(1, 4'b0100, "reen_after");

        // 6: reset in the middle of SETTLE after 00 -> 10
        key0 = 2'b00;
        quiet0(4, 4'b0100, "to00_settle");
        commit0(4'b0001, 2'b00, "to00_commit");
        quiet0(1, 4'b0001, "to00_after");
        key0 = 2'b10;
        quiet0(2, 4'b0001, "pre_rst");
        rst = 1'b1;
        tick();
        check_val("mid_rst_opt", {4'd0, opt0}, 8'd0);
        check_val("mid_rst_valid", {7'd0, valid0}, 8'd0);
        check_val("mid_rst_code", {6'd0, code0}, 8'd0);
        tick();
        rst = 1'b0;
        quiet0(4, 4'b0000, "post_rst_settle");
        commit0(4'b0100, 2'b10, "post_rst_commit");
        quiet0(1, 4'b0100, "post_rst_after");

        // 5: pulse mode, key=11 stable, enable -> single-cycle opt
        en_p = 1'b1;
        tick();
        check_val("pm_settle_opt", {4'd0, opt_p}, 8'd0);
        check_val("pm_settle_valid", {7'd0, valid_p}, 8'd0);
        tick();
        check_val("pm_commit_opt", {4'd0, opt_p}, 8'h08);
        check_val("pm_commit_valid", {7'd0, valid_p}, 8'd1);
        check_val("pm_commit_code", {6'd0, code_p}, 8'd3);
        tick();
        check_val("pm_after_opt", {4'd0, opt_p}, 8'd0);
        check_val("pm_after_valid", {7'd0, valid_p}, 8'd0);
        key_p = 2'b01;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val("pm_chg_opt", {4'd0, opt_p}, 8'd0);
            check_val("pm_chg_valid", {7'd0, valid_p}, 8'd0);
        end
        tick();
        check_val("pm_chg_commit_opt", {4'd0, opt_p}, 8'h02);
        check_val("pm_chg_commit_valid", {7'd0, valid_p}, 8'd1);
        tick();
        check_val("pm_chg_after_opt", {4'd0, opt_p}, 8'd0);
        check_val("pm_chg_code", {6'd0, code_p}, 8'd1);

        // STABLE_CYCLES=1: enable commits on 2nd edge, key change 2 edges later
        en_s = 1'b1;
        tick();
        check_val("s1_en_valid", {7'd0, valid_s}, 8'd0);
        tick();
        check_val("s1_en_commit_valid", {7'd0, valid_s}, 8'd1);
        check_val("s1_en_commit_opt", {4'd0, opt_s}, 8'h01);
        key_s = 2'b10;
        tick();
        check_val("s1_chg_valid", {7'd0, valid_s}, 8'd0);
        check_val("s1_chg_opt", {4'd0, opt_s}, 8'h01);
        tick();
        check_val("s1_chg_commit_valid", {7'd0, valid_s}, 8'd1);
        check_val("s1_chg_commit_opt", {4'd0, opt_s}, 8'h04);
        check_val("s1_chg_commit_code", {6'd0, code_s}, 8'd2);
        tick();
        check_val("s1_after_valid", {7'd0, valid_s}, 8'd0);
        check_val("s1_after_opt", {4'd0, opt_s}, 8'h04);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
